zxuno_devopt_bank: RTL and testbench

- Parametrised device-options register bank for the ZXUNO register space.
- Holds NREGS contiguous 8-bit option registers at BASE_ADDR..BASE_ADDR+NREGS-1, with per-bit compile-time forcing for features that are not built in.
- Option writes can take effect either immediately or at the next video frame boundary (per-register selection), so mode changes never tear mid-frame.
- A lock register with a two-write unlock key protects the options from runaway software.
- Feeds disable/enable strobes to the ULA, audio, memory-paging and SPI blocks.

---
 rtl/zxuno_devopt_pkg.sv | 40 ++++
 rtl/zxuno_devopt_bank_if.sv | 19 +
 rtl/zxuno_devopt_lock_fsm.sv | 50 +++++
 rtl/zxuno_devopt_bank.sv | 121 ++++++++++++
 tb/tb_zxuno_devopt_bank.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/zxuno_devopt_pkg.sv
// Shared constants, lock-state encoding and the force-mask helper for the
// ZXUNO device-options register bank.
package zxuno_devopt_pkg;

    localparam logic [7:0] DEVOPTIONS = 8'h0E;
    localparam logic [7:0] DEVOPTS2   = 8'h0F;
    localparam logic [7:0] DEVOPTLOCK = 8'h10;

    localparam logic [7:0] UNLOCK_KEY1 = 8'h55;
    localparam logic [7:0] UNLOCK_KEY2 = 8'hAA;

    typedef enum logic [1:0] {
        LK_UNLOCKED = 2'd0,
        LK_LOCKED   = 2'd1,
        LK_KEY1     = 2'd2
    } lock_state_e;

    // Bit positions inside the flattened opts vector
    localparam int DISABLE_AY        = 0;
    localparam int DISABLE_TURBOAY   = 1;
    localparam int DISABLE_7FFD      = 2;
    localparam int DISABLE_1FFD      = 3;
    localparam int DISABLE_ROMSEL    = 4;
    localparam int DISABLE_INTEVEN   = 5;
    localparam int DISABLE_CONTENDED = 6;
    localparam int DISABLE_SPISD     = 7;
    localparam int DISABLE_ULAPLUS   = 8;
    localparam int DISABLE_TIMEX     = 9;
    localparam int DISABLE_RADASTAN  = 10;
    localparam int DISABLE_SPECDRUM  = 11;
    localparam int DISABLE_MIXER     = 12;

    // Forced bits replace stored bits so features not built in read back fixed.
    function automatic logic [7:0] effective(input logic [7:0] v,
                                             input logic [7:0] mask,
                                             input logic [7:0] val);
        return (v & ~mask) | (val & mask);
    endfunction

endpackage

// File: rtl/zxuno_devopt_bank_if.sv
// ZXUNO register-space access bus: address, strobes, write data and read return.
interface zxuno_devopt_bank_if;
    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       zxuno_regwr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe;

    modport master (
        output zxuno_addr, zxuno_regrd, zxuno_regwr, din,
        input  dout, oe
    );

    modport slave (
        input  zxuno_addr, zxuno_regrd, zxuno_regwr, din,
        output dout, oe
    );
endinterface

// File: rtl/zxuno_devopt_lock_fsm.sv
// Lock state machine with two-write unlock key and sticky violation flag.
module zxuno_devopt_lock_fsm
    import zxuno_devopt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_lock,
    input  logic [7:0] din,
    input  logic       rd_lock,
    input  logic       opt_wr_attempt,
    output logic       locked,
    output logic       key1,
    output logic       sticky
);

    lock_state_e state_q = LK_UNLOCKED;
    lock_state_e state_d;
    logic        sticky_q = 1'b0;
    logic        sticky_d;

    always_comb begin
        state_d  = state_q;
        sticky_d = sticky_q;
        if (wr_lock) begin
            case (state_q)
                LK_UNLOCKED: if (din[0]) state_d = LK_LOCKED;
                LK_LOCKED:   if (din == UNLOCK_KEY1) state_d = LK_KEY1;
                LK_KEY1:     state_d = (din == UNLOCK_KEY2) ? LK_UNLOCKED : LK_LOCKED;
                default:     state_d = LK_LOCKED;
            endcase
        end
        // A violation in the same cycle as a status read must survive the clear
        if (rd_lock) sticky_d = 1'b0;
        if (opt_wr_attempt && state_q != LK_UNLOCKED) sticky_d = 1'b1;
        if (!rst_n) begin
            state_d  = LK_UNLOCKED;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        sticky_q <= sticky_d;
    end

    assign locked = (state_q != LK_UNLOCKED);
    assign key1   = (state_q == LK_KEY1);
    assign sticky = sticky_q;

endmodule

// File: rtl/zxuno_devopt_bank.sv
// Device-options register bank: shadow/live option bytes with per-register
// frame-synchronous apply, compile-time forced bits and a lock register.
module zxuno_devopt_bank
    import zxuno_devopt_pkg::*;
#(
    parameter int                 NREGS      = 2,
    parameter logic [7:0]         BASE_ADDR  = DEVOPTIONS,
    parameter logic [7:0]         LOCK_ADDR  = DEVOPTLOCK,
    parameter logic [NREGS*8-1:0] INIT_VAL   = (NREGS*8)'(16'h0028),
    parameter logic [NREGS*8-1:0] RESET_VAL  = '0,
    parameter logic [NREGS*8-1:0] FORCE_MASK = '0,
    parameter logic [NREGS*8-1:0] FORCE_VAL  = '0,
    parameter logic [NREGS-1:0]   DEFER_MASK = NREGS'(2'b10)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    zxuno_devopt_bank_if.slave   bus,
    input  logic                 frame_sync,
    output wire  [NREGS*8-1:0]   opts,
    output logic                 pending,
    output logic                 locked
);

    logic [NREGS-1:0]   sel;
    wire  [NREGS*8-1:0] shadow_all;
    wire  [NREGS-1:0]   pend_vec;
    logic               lock_sel;
    logic               key1;
    logic               sticky;
    logic               wr_ok;

    assign lock_sel = (bus.zxuno_addr == LOCK_ADDR);
    assign wr_ok    = bus.zxuno_regwr && !locked;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            localparam logic [7:0] REG_ADDR = BASE_ADDR + 8'(gi);
            localparam logic [7:0] FMASK    = FORCE_MASK[gi*8 +: 8];
            localparam logic [7:0] FVAL     = FORCE_VAL[gi*8 +: 8];
            localparam logic [7:0] INIT_EFF = effective(INIT_VAL[gi*8 +: 8], FMASK, FVAL);
            localparam logic [7:0] RST_EFF  = effective(RESET_VAL[gi*8 +: 8], FMASK, FVAL);

            logic [7:0] shadow_q = INIT_EFF;
            logic [7:0] live_q   = INIT_EFF;
            logic       pend_q   = 1'b0;
            logic [7:0] shadow_d;
            logic [7:0] live_d;
            logic       pend_d;
            logic [7:0] eff_din;
            logic       wr_en;

            assign sel[gi]  = (bus.zxuno_addr == REG_ADDR);
            assign eff_din  = effective(bus.din, FMASK, FVAL);
            assign wr_en    = wr_ok && sel[gi];

            always_comb begin
                shadow_d = shadow_q;
                live_d   = live_q;
                pend_d   = pend_q;
                if (wr_en) begin
                    shadow_d = eff_din;
                    if (DEFER_MASK[gi]) pend_d = 1'b1;
                    else                live_d = eff_din;
                end
                // Applying after the write lets a same-cycle write go straight live
                if (frame_sync && pend_d) begin
                    live_d = shadow_d;
                    pend_d = 1'b0;
                end
                if (!rst_n) begin
                    shadow_d = RST_EFF;
                    live_d   = RST_EFF;
                    pend_d   = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                shadow_q <= shadow_d;
                live_q   <= live_d;
                pend_q   <= pend_d;
            end

            assign opts[gi*8 +: 8]       = live_q;
            assign shadow_all[gi*8 +: 8] = shadow_q;
            assign pend_vec[gi]          = pend_q;
        end
    endgenerate

    assign pending = |pend_vec;

    zxuno_devopt_lock_fsm u_lock (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_lock        (bus.zxuno_regwr && lock_sel),
        .din            (bus.din),
        .rd_lock        (bus.zxuno_regrd && lock_sel),
        .opt_wr_attempt (bus.zxuno_regwr && (|sel)),
        .locked         (locked),
        .key1           (key1),
        .sticky         (sticky)
    );

    always_comb begin
        bus.oe   = 1'b0;
        bus.dout = 8'hFF;
        if (bus.zxuno_regrd) begin
            for (int i = 0; i < NREGS; i++) begin
                if (sel[i]) begin
                    bus.oe   = 1'b1;
                    bus.dout = shadow_all[i*8 +: 8];
                end
            end
            if (lock_sel) begin
                bus.oe   = 1'b1;
                bus.dout = {5'b0, key1, sticky, locked};
            end
        end
    end

endmodule

// File: tb/tb_zxuno_devopt_bank.sv
// Scoreboard bench: two bank instances (plain and bit-7 forced) driven in lockstep
// and checked against a behavioural register-bank model.
module tb_zxuno_devopt_bank;

    localparam int NREGS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic frame_sync = 1'b0;
    always #5 clk = ~clk;

    zxuno_devopt_bank_if bus0();
    zxuno_devopt_bank_if bus1();

    wire [15:0] opts0;
    wire [15:0] opts1;
    logic       pend0, pend1, lock0, lock1;

    zxuno_devopt_bank u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .frame_sync(frame_sync),
        .opts(opts0), .pending(pend0), .locked(lock0)
    );

    zxuno_devopt_bank #(.FORCE_MASK(16'h0080), .FORCE_VAL(16'h0080)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .frame_sync(frame_sync),
        .opts(opts1), .pending(pend1), .locked(lock1)
    );

    typedef struct {
        string       tag;
        logic [1:0]  oe;
        logic [15:0] dout;
        logic [31:0] opts;
        logic [1:0]  pend;
        logic [1:0]  lock;
    } exp_t;

    exp_t scb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    // Behavioural model: one copy per instance
    logic [7:0] m_shadow [2][NREGS];
    logic [7:0] m_live   [2][NREGS];
    bit         m_pend   [2][NREGS];
    int         m_state  [2];          // 0 unlocked, 1 locked, 2 first key seen
    bit         m_sticky [2];

    function automatic logic [7:0] eff(input int dd, input int i, input logic [7:0] v);
        logic [7:0] m;
        m = (dd == 1 && i == 0) ? 8'h80 : 8'h00;
        return (v & ~m) | (8'h80 & m);
    endfunction

    function automatic int reg_index(input logic [7:0] a);
        int k;
        k = int'(a) - 14;
        return (k >= 0 && k < NREGS) ? k : -1;
    endfunction

    task automatic model_load(input bit pwr);
        for (int dd = 0; dd < 2; dd++) begin
            for (int i = 0; i < NREGS; i++) begin
                m_shadow[dd][i] = eff(dd, i, (pwr && i == 0) ? 8'h28 : 8'h00);
                m_live[dd][i]   = m_shadow[dd][i];
                m_pend[dd][i]   = 1'b0;
            end
            m_state[dd]  = 0;
            m_sticky[dd] = 1'b0;
        end
    endtask

    task automatic check(input string tag, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s/%s: got %h, expected %h", tag, name, act, req);
        end
    endtask

    task automatic step(input bit rn, input bit wr, input bit rd,
                        input logic [7:0] a, input logic [7:0] d,
                        input bit fs, input string tag);
        exp_t e;
        int   idx;
        bit   viol;
        logic [7:0] v;
        @(posedge clk);
        #1;
        rst_n = rn;
        frame_sync = fs;
        bus0.zxuno_regwr = wr; bus0.zxuno_regrd = rd; bus0.zxuno_addr = a; bus0.din = d;
        bus1.zxuno_regwr = wr; bus1.zxuno_regrd = rd; bus1.zxuno_addr = a; bus1.din = d;
        idx = reg_index(a);
        e.tag = tag;
        for (int dd = 0; dd < 2; dd++) begin
            e.oe[dd] = 1'b0;
            e.dout[dd*8 +: 8] = 8'hFF;
            if (rd && idx >= 0) begin
                e.oe[dd] = 1'b1;
                e.dout[dd*8 +: 8] = m_shadow[dd][idx];
            end else if (rd && a == 8'h10) begin
                e.oe[dd] = 1'b1;
                e.dout[dd*8 +: 8] = {5'b0, m_state[dd] == 2, m_sticky[dd], m_state[dd] != 0};
            end
            e.opts[dd*16 +: 16] = {m_live[dd][1], m_live[dd][0]};
            e.pend[dd] = m_pend[dd][0] | m_pend[dd][1];
            e.lock[dd] = (m_state[dd] != 0);
        end
        scb.push_back(e);
        if (!rn) begin
            model_load(1'b0);
        end else begin
            for (int dd = 0; dd < 2; dd++) begin
                viol = 1'b0;
                if (wr && idx >= 0) begin
                    if (m_state[dd] != 0) viol = 1'b1;
                    else begin
                        v = eff(dd, idx, d);
                        m_shadow[dd][idx] = v;
                        if (idx == 1) m_pend[dd][idx] = 1'b1;
                        else          m_live[dd][idx] = v;
                    end
                end
                if (fs) begin
                    for (int i = 0; i < NREGS; i++) begin
                        if (m_pend[dd][i]) begin
                            m_live[dd][i] = m_shadow[dd][i];
                            m_pend[dd][i] = 1'b0;
                        end
                    end
                end
                if (wr && a == 8'h10) begin
                    case (m_state[dd])
                        0:       m_state[dd] = d[0] ? 1 : 0;
                        1:       m_state[dd] = (d == 8'h55) ? 2 : 1;
                        default: m_state[dd] = (d == 8'hAA) ? 0 : 1;
                    endcase
                end
                if (rd && a == 8'h10) m_sticky[dd] = 1'b0;
                if (viol) m_sticky[dd] = 1'b1;
            end
        end
    endtask

    task automatic idle(input string tag);           step(1, 0, 0, 8'h00, 8'h00, 0, tag); endtask
    task automatic rdr(input logic [7:0] a, input string tag); step(1, 0, 1, a, 8'h00, 0, tag); endtask
    task automatic wrr(input logic [7:0] a, input logic [7:0] d, input string tag); step(1, 1, 0, a, d, 0, tag); endtask

    // Monitor: pops one expectation per cycle and compares at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (scb.size() > 0) begin
                e = scb.pop_front();
                n_txn++;
                check(e.tag, "oe0",   32'(bus0.oe),   32'(e.oe[0]));
                check(e.tag, "dout0", 32'(bus0.dout), 32'(e.dout[7:0]));
                check(e.tag, "oe1",   32'(bus1.oe),   32'(e.oe[1]));
                check(e.tag, "dout1", 32'(bus1.dout), 32'(e.dout[15:8]));
                check(e.tag, "opts0", 32'(opts0),     32'(e.opts[15:0]));
                check(e.tag, "opts1", 32'(opts1),     32'(e.opts[31:16]));
                check(e.tag, "pend0", 32'(pend0),     32'(e.pend[0]));
                check(e.tag, "pend1", 32'(pend1),     32'(e.pend[1]));
                check(e.tag, "lock0", 32'(lock0),     32'(e.lock[0]));
                check(e.tag, "lock1", 32'(lock1),     32'(e.lock[1]));
                $display("txn %0d %s: oe=%b%b dout=%h/%h opts=%h/%h pend=%b%b lock=%b%b",
                         n_txn, e.tag, bus0.oe, bus1.oe, bus0.dout, bus1.dout,
                         opts0, opts1, pend0, pend1, lock0, lock1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, d;
        logic [7:0] key_tab [4];
        logic [7:0] addr_tab [6];
        int k;
        key_tab  = '{8'h55, 8'hAA, 8'h01, 8'h00};
        addr_tab = '{8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h15};
        bus0.zxuno_regwr = 0; bus0.zxuno_regrd = 0; bus0.zxuno_addr = 0; bus0.din = 0;
        bus1.zxuno_regwr = 0; bus1.zxuno_regrd = 0; bus1.zxuno_addr = 0; bus1.din = 0;
        model_load(1'b1);

        rdr(8'h0E, "pwr_rd0e");
        step(0, 0, 0, 8'h00, 8'h00, 0, "reset");
        idle("post_reset");
        wrr(8'h0E, 8'hC3, "wr0e_c3");
        idle("imm_c3");
        wrr(8'h0E, 8'h00, "wr0e_00");
        rdr(8'h0E, "rd0e_forced");
        wrr(8'h0F, 8'h1F, "wr0f_1f");
        rdr(8'h0F, "rd0f_pend");
        step(1, 0, 0, 8'h00, 8'h00, 1, "frame");
        idle("applied_1f");
        step(1, 1, 0, 8'h0F, 8'h05, 1, "wr0f_frame");
        idle("applied_05");
        wrr(8'h10, 8'h01, "lock");
        idle("locked");
        wrr(8'h0E, 8'hFF, "wr_blocked");
        rdr(8'h10, "status_sticky");
        rdr(8'h10, "status_clr");
        wrr(8'h10, 8'h55, "key1");
        rdr(8'h10, "status_key1");
        wrr(8'h10, 8'hAA, "key2");
        wrr(8'h0E, 8'hFF, "wr_unlocked");
        idle("opt_ff");
        wrr(8'h10, 8'h01, "relock");
        wrr(8'h10, 8'h55, "bad_k1");
        wrr(8'h10, 8'h12, "bad_k2");
        rdr(8'h10, "status_bad");
        wrr(8'h10, 8'h55, "abort_k1");
        step(0, 0, 0, 8'h00, 8'h00, 0, "abort_rst");
        rdr(8'h10, "status_rst");
        rdr(8'h11, "dec_11");
        rdr(8'h0D, "dec_0d");
        rdr(8'h15, "dec_15");
        step(1, 0, 0, 8'h0E, 8'h00, 0, "no_rd_0e");

        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 7);
            a = (k < 6) ? addr_tab[k] : 8'($urandom);
            d = ($urandom_range(0, 3) == 0) ? key_tab[$urandom_range(0, 3)] : 8'($urandom);
            step($urandom_range(0, 59) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, a, d, $urandom_range(0, 5) == 0, "rand");
        end
        idle("drain");

        k = 0;
        while (scb.size() > 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        if (scb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", scb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
